sram_input_ctrl: RTL and testbench

//  Sequencer for the 784x16 input-image SRAM (one 28x28 frame). LOAD phase: accepts a

---
 rtl/sram_input_ctrl.sv | 120 ++++++++++++
 tb/tb_sram_input_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_input_ctrl.sv
// Input-image SRAM sequencer: LOAD writes a valid/ready pixel stream to addresses
// 0..DEPTH-1, READ replays the stored frame in address order with back-pressure.
module sram_input_ctrl #(
    parameter int DEPTH = 784,
    parameter int AW    = 10,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          read_start,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          load_done,
    output logic          read_done,
    output logic          busy,
    output logic          sram_we,
    output logic [DW-1:0] sram_d,
    output logic [AW-1:0] sram_address,
    input  logic [DW-1:0] sram_q
);

    typedef enum logic [1:0] {IDLE, LOAD, FULL, READ} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   rd_ptr;     // one extra bit so it can reach DEPTH when DEPTH == 2**AW
    logic [AW-1:0] hold_addr;

    logic beat, last_beat, issue, accept_last, start_load, start_read;

    assign beat        = (state == LOAD) && in_valid;
    assign last_beat   = beat && (wr_ptr == AW'(DEPTH - 1));
    assign issue       = (state == READ) && (rd_ptr < (AW+1)'(DEPTH)) && (!out_valid || out_ready);
    assign accept_last = (state == READ) && out_valid && out_ready && (hold_addr == AW'(DEPTH - 1));
    assign start_load  = ((state == IDLE) || (state == FULL)) && load_start;
    assign start_read  = (state == FULL) && read_start && !load_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load_start) state_nxt = LOAD;
            LOAD: if (last_beat) state_nxt = FULL;
            FULL: begin
                if (load_start)      state_nxt = LOAD;
                else if (read_start) state_nxt = READ;
            end
            READ: if (accept_last) state_nxt = FULL;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hold_addr <= '0;
            out_valid <= 1'b0;
            load_done <= 1'b0;
            read_done <= 1'b0;
        end else begin
            load_done <= last_beat;
            read_done <= accept_last;

            if (start_load)
                wr_ptr <= '0;
            else if (beat && !last_beat)
                wr_ptr <= wr_ptr + AW'(1);

            // A stalled word keeps its address on the bus so the registered
            // SRAM output stays stable until the consumer takes it.
            if (start_read) begin
                rd_ptr    <= '0;
                out_valid <= 1'b0;
            end else if (issue) begin
                hold_addr <= rd_ptr[AW-1:0];
                rd_ptr    <= rd_ptr + (AW+1)'(1);
                out_valid <= 1'b1;
            end else if ((state == READ) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        in_ready     = 1'b0;
        busy         = 1'b0;
        sram_we      = 1'b0;
        sram_d       = '0;
        sram_address = '0;
        case (state)
            LOAD: begin
                in_ready     = 1'b1;
                busy         = 1'b1;
                sram_we      = in_valid;
                sram_d       = in_data;
                sram_address = wr_ptr;
            end
            READ: begin
                busy         = 1'b1;
                sram_address = issue ? rd_ptr[AW-1:0] : hold_addr;
            end
            default: ;
        endcase
    end

    assign out_data = sram_q;
    assign out_last = out_valid && (hold_addr == AW'(DEPTH - 1));

endmodule

// File: tb/tb_sram_input_ctrl.sv
// Bench for sram_input_ctrl: SRAM model plus a frame-level reference (array of stored
// pixels, expected replay order) driven with random gaps and back-pressure.
module tb_sram_input_ctrl;

    localparam int DEPTH = 784;
    localparam int AW    = 10;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start, in_valid, read_start, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid, out_last, load_done, read_done, busy, sram_we;
    logic [DW-1:0] out_data, sram_d, sram_q;
    logic [AW-1:0] sram_address;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ref_frame [DEPTH];
    logic [DW-1:0] mem [0:(1<<AW)-1];

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t wlog[$];

    wire [AW+DW+6:0] rst_vec = {in_ready, out_valid, out_last, load_done, read_done,
                                busy, sram_we, sram_d, sram_address};

    sram_input_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .read_start(read_start),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .load_done(load_done), .read_done(read_done),
        .busy(busy), .sram_we(sram_we), .sram_d(sram_d),
        .sram_address(sram_address), .sram_q(sram_q)
    );

    always #5 clk = ~clk;

    // Registered-read SRAM plus a log of every write the controller issues.
    always @(posedge clk) begin
        if (sram_we === 1'b1) begin
            mem[sram_address] <= sram_d;
            wlog.push_back('{sram_address, sram_d});
        end
        sram_q <= mem[sram_address];
    end

    task automatic do_load(input int gap, input bit rnd, input bit both,
                           input bit inject, input int stop_at);
        int k = 0;
        int cyc = 0;
        bit v;
        bit bad;
        logic [DW-1:0] d;
        wlog.delete();
        @(negedge clk); load_start = 1'b1; read_start = both;
        @(negedge clk); load_start = 1'b0; read_start = 1'b0;
        while (k < stop_at) begin
            v = (int'($urandom_range(99)) >= gap);
            d = rnd ? DW'($urandom) : DW'(k - 392);
            in_valid = v; in_data = d;
            load_start = inject && (k == 100);
            read_start = inject && (k == 200);
            #1;
            checks++;
            if (in_ready !== 1'b1 || busy !== 1'b1 || load_done !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL load_status k=%0d: in_ready=%b busy=%b load_done=%b out_valid=%b, need 1 1 0 0",
                         k, in_ready, busy, load_done, out_valid);
            end
            checks++;
            if (sram_we !== v) begin
                errors++;
                $display("FAIL load_we k=%0d: sram_we=%b need %b", k, sram_we, v);
            end
            if (v) begin
                checks++;
                if (sram_address !== AW'(k) || sram_d !== d) begin
                    errors++;
                    $display("FAIL load_write k=%0d: addr=%0d d=%h need addr=%0d d=%h",
                             k, sram_address, sram_d, k, d);
                end
                ref_frame[k] = d;
                k++;
            end
            @(negedge clk);
            cyc++;
            if (cyc > 8000) begin
                errors++;
                $display("FAIL load_timeout: %0d beats accepted, need %0d", k, stop_at);
                break;
            end
        end
        in_valid = 1'b0; load_start = 1'b0; read_start = 1'b0;
        if (stop_at < DEPTH) return;
        #1;
        checks++;
        if (load_done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_done_pulse: load_done=%b in_ready=%b busy=%b need 1 0 0",
                     load_done, in_ready, busy);
        end
        bad = (wlog.size() != DEPTH);
        if (!bad)
            foreach (wlog[i])
                if (wlog[i].a !== AW'(i) || wlog[i].d !== ref_frame[i]) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL write_log: %0d writes logged, need %0d in order 0..%0d with frame data",
                     wlog.size(), DEPTH, DEPTH - 1);
        end
        @(negedge clk); #1;
        checks++;
        if (load_done !== 1'b0) begin
            errors++;
            $display("FAIL load_done_width: load_done=%b need 0", load_done);
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic do_read(input int mode, input bit inject, input int stop_at);
        int idx = 0;
        int cyc = 0;
        bit rdy;
        @(negedge clk); read_start = 1'b1;
        @(negedge clk); read_start = 1'b0;
        while (idx < stop_at) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: rdy = 1'($urandom_range(1));
            endcase
            out_ready  = rdy;
            load_start = inject && (idx == 100);
            read_start = inject && (idx == 200);
            #1;
            checks++;
            if (busy !== 1'b1 || sram_we !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL read_status idx=%0d: busy=%b sram_we=%b in_ready=%b need 1 0 0",
                         idx, busy, sram_we, in_ready);
            end
            if (cyc == 0) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL read_latency: out_valid=%b in first READ cycle need 0", out_valid);
                end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (out_data !== ref_frame[idx] || out_last !== (idx == DEPTH - 1)) begin
                    errors++;
                    $display("FAIL read_word idx=%0d: data=%h last=%b need data=%h last=%b",
                             idx, out_data, out_last, ref_frame[idx], (idx == DEPTH - 1));
                end
                if (rdy) idx++;
            end
            @(negedge clk);
            cyc++;
            if (cyc > 12000) begin
                errors++;
                $display("FAIL read_timeout: %0d words received, need %0d", idx, stop_at);
                break;
            end
        end
        load_start = 1'b0; read_start = 1'b0;
        if (stop_at < DEPTH) return;
        if (mode == 0) begin
            checks++;
            if (cyc != DEPTH + 1) begin
                errors++;
                $display("FAIL read_throughput: %0d cycles need %0d", cyc, DEPTH + 1);
            end
        end
        #1;
        checks++;
        if (read_done !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL read_done_pulse: read_done=%b out_valid=%b out_last=%b busy=%b need 1 0 0 0",
                     read_done, out_valid, out_last, busy);
        end
        @(negedge clk); #1;
        checks++;
        if (read_done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_done_width: read_done=%b out_valid=%b need 0 0", read_done, out_valid);
        end
    endtask

    task automatic test_reset;
        load_start = 1'b1; read_start = 1'b1; in_valid = 1'b1; in_data = 16'h7fff; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (rst_vec !== '0) begin
            errors++;
            $display("FAIL reset_values: outputs=%h need 0", rst_vec);
        end
        @(negedge clk);
        rst = 1'b0; load_start = 1'b0; read_start = 1'b1;
        #1;
        checks++;
        if (rst_vec !== '0) begin
            errors++;
            $display("FAIL idle_outputs: outputs=%h need 0", rst_vec);
        end
        @(negedge clk); read_start = 1'b0; in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_read_ignored: busy=%b out_valid=%b need 0 0", busy, out_valid);
            end
        end
    endtask

    task automatic test_load_contiguous;  do_load(0, 1'b0, 1'b0, 1'b0, DEPTH); endtask
    task automatic test_read_full;        do_read(0, 1'b0, DEPTH);               endtask
    task automatic test_read_backpressure; do_read(1, 1'b0, DEPTH);              endtask
    task automatic test_load_gaps;        do_load(50, 1'b1, 1'b0, 1'b1, DEPTH);  endtask
    task automatic test_read_random;      do_read(2, 1'b1, DEPTH);               endtask

    task automatic test_start_priority;
        do_load(0, 1'b1, 1'b1, 1'b0, DEPTH);
        do_read(0, 1'b0, DEPTH);
    endtask

    task automatic test_rst_mid_load;
        do_load(0, 1'b1, 1'b0, 1'b0, 300);
        in_valid = 1'b1; in_data = 16'h1234;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rst_vec !== '0) begin
            errors++;
            $display("FAIL rst_mid_load: outputs=%h need 0", rst_vec);
        end
        @(posedge clk);
        @(negedge clk); rst = 1'b0; in_valid = 1'b0; read_start = 1'b1;
        @(negedge clk); read_start = 1'b0;
        repeat (4) begin
            #1;
            checks++;
            if (load_done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL after_rst_load: load_done=%b busy=%b out_valid=%b need 0 0 0",
                         load_done, busy, out_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rst_mid_read;
        do_load(0, 1'b1, 1'b0, 1'b0, DEPTH);
        do_read(2, 1'b0, 500);
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rst_vec !== '0) begin
            errors++;
            $display("FAIL rst_mid_read: outputs=%h need 0", rst_vec);
        end
        @(posedge clk);
        @(negedge clk); rst = 1'b0; out_ready = 1'b1; read_start = 1'b1;
        @(negedge clk); read_start = 1'b0;
        repeat (4) begin
            #1;
            checks++;
            if (read_done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL after_rst_read: read_done=%b busy=%b out_valid=%b need 0 0 0",
                         read_done, busy, out_valid);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; read_start = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset;
        test_load_contiguous;
        test_read_full;
        test_read_backpressure;
        test_load_gaps;
        test_read_random;
        test_start_priority;
        test_rst_mid_load;
        test_rst_mid_read;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
